// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: sends a 48-bit command frame with CRC7 and optionally receives a 48/136-bit response.
// Define SD_CMD_CRC_CHECK_EN to build the receive CRC7 check; otherwise rsp_crc_err is tied to 0.
module sd_cmd_phy #(
    parameter int NCR_MAX = 64,
    parameter int NCC     = 8
) (
    input  logic         SD_clk,
    input  logic         RST_L,
    input  logic         cmd_start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   rsp_type,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_busy,
    output logic         cmd_done,
    output logic         rsp_timeout,
    output logic         rsp_err,
    output logic         rsp_crc_err,
    output logic [5:0]   rsp_index,
    output logic [127:0] rsp_data
);
    localparam logic [7:0] NCR_LAST = 8'(NCR_MAX);
    localparam logic [7:0] GAP_LAST = 8'(NCC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_GAP,
        S_DONE
    } state_t;

    state_t       state, state_next;
    logic [7:0]   cnt, cnt_next;
    logic [1:0]   rtype;
    logic [39:0]  tx_hdr;
    logic [47:0]  tx_sr;
    logic [126:0] rx_sr;
    logic [127:0] rx_next;
    logic         rx_tbit;
    logic         accept, long_rsp, start_bit, wait_expired, rx_last, gap_last;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    assign tx_hdr       = {2'b01, cmd_index, cmd_arg};
    assign accept       = ((state == S_IDLE) || (state == S_DONE)) && cmd_start;
    assign long_rsp     = (rtype == 2'b10);
    assign start_bit    = (state == S_WAIT) && !cmd_in;
    assign wait_expired = (state == S_WAIT) && cmd_in && (cnt == NCR_LAST);
    assign rx_last      = (state == S_RECV) && (cnt == (long_rsp ? 8'd135 : 8'd47));
    assign gap_last     = (state == S_GAP) && (cnt == GAP_LAST);
    // rx_next holds the newest bit in [0]; bits above the frame length are stale and never used.
    assign rx_next      = {rx_sr, cmd_in};

    assign cmd_oe   = (state == S_SEND);
    assign cmd_out  = (state == S_SEND) ? tx_sr[47] : 1'b1;
    assign cmd_busy = (state != S_IDLE) && (state != S_DONE);
    assign cmd_done = (state == S_DONE);

    always_ff @(posedge SD_clk) begin
        if (!RST_L) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt is the 1-based cycle number within SEND/WAIT/GAP and the bit number after the start bit in RECV.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 8'd1;
        unique case (state)
            S_IDLE, S_DONE: begin
                state_next = cmd_start ? S_SEND : S_IDLE;
                cnt_next   = 8'd1;
            end
            S_SEND: begin
                if (cnt == 8'd48) begin
                    state_next = (rtype == 2'b00) ? S_GAP : S_WAIT;
                    cnt_next   = 8'd1;
                end
            end
            S_WAIT: begin
                if (start_bit) begin
                    state_next = S_RECV;
                    cnt_next   = 8'd1;
                end else if (wait_expired) begin
                    state_next = S_GAP;
                    cnt_next   = 8'd1;
                end
            end
            S_RECV: begin
                if (rx_last) begin
                    state_next = S_GAP;
                    cnt_next   = 8'd1;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 8'd1;
            end
        endcase
    end

    always_ff @(posedge SD_clk) begin
        if (!RST_L) begin
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_index   <= '0;
            rsp_data    <= '0;
        end else begin
            if (accept) begin
                rsp_timeout <= 1'b0;
                rsp_err     <= 1'b0;
            end
            if (wait_expired) begin
                rsp_timeout <= 1'b1;
            end
            if (rx_last) begin
                rsp_err <= rx_tbit | ~rx_next[0];
                if (long_rsp) begin
                    rsp_index <= '0;
                    rsp_data  <= rx_next;
                end else begin
                    rsp_index <= rx_next[45:40];
                    rsp_data  <= {96'b0, rx_next[39:8]};
                end
            end
        end
    end

    always_ff @(posedge SD_clk) begin
        if (accept) begin
            rtype <= rsp_type;
            tx_sr <= {tx_hdr, crc7_40(tx_hdr), 1'b1};
        end else if (state == S_SEND) begin
            tx_sr <= {tx_sr[46:0], 1'b1};
        end
        if (state == S_RECV) begin
            rx_sr <= rx_next[126:0];
            if (cnt == 8'd1) begin
                rx_tbit <= cmd_in;
            end
        end
    end

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       crc_bad;
    logic       crc_span;

    // The start bit is 0 and leaves a zero CRC unchanged, so the 48-bit check begins at the transmission bit.
    assign crc_span = long_rsp ? ((cnt >= 8'd8) && (cnt <= 8'd127)) : (cnt <= 8'd39);

    always_ff @(posedge SD_clk) begin
        if (!RST_L) begin
            rsp_crc_err <= 1'b0;
            crc_bad     <= 1'b0;
        end else begin
            if (accept) begin
                rsp_crc_err <= 1'b0;
                crc_bad     <= 1'b0;
            end
            if (rx_last) begin
                crc_bad <= (rtype != 2'b11) && (rx_crc != rx_next[7:1]);
            end
            if (gap_last) begin
                rsp_crc_err <= crc_bad;
            end
        end
    end

    always_ff @(posedge SD_clk) begin
        if (start_bit) begin
            rx_crc <= '0;
        end else if ((state == S_RECV) && crc_span) begin
            rx_crc <= crc7_step(rx_crc, cmd_in);
        end
    end
`else
    assign rsp_crc_err = 1'b0;
`endif

endmodule
